// File: rtl/hpc3_and_pipe.sv
// rtl/hpc3_and_pipe.sv - two-stage HPC3 masked AND gadget over SHARES Boolean shares
// Stage 1 registers masked partial products; stage 2 recombines them into the output shares c.
module hpc3_and_pipe #(
  parameter int WIDTH  = 8,
  parameter int SHARES = 3,
  localparam int NPAIR = SHARES * (SHARES - 1) / 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SHARES*WIDTH-1:0]   a,
  input  logic [SHARES*WIDTH-1:0]   b,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NPAIR*WIDTH-1:0]    r,
  input  logic [NPAIR*WIDTH-1:0]    p,
  input  logic                      rnd_valid,
  output logic [SHARES*WIDTH-1:0]   c,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NORD = SHARES * (SHARES - 1);

  // Unordered pair (i,j) -> lexicographic index into r/p; symmetric so r_ij = r_ji.
  function automatic int pair_idx(input int i, input int j);
    int lo, hi, k;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    k  = 0;
    for (int m = 0; m < lo; m++) k += SHARES - 1 - m;
    return k + (hi - lo - 1);
  endfunction

  // Ordered pair (i,j), i != j -> dense slot for the per-pair stage-1 registers.
  function automatic int ord_idx(input int i, input int j);
    return i * (SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  logic s1_valid;
  logic s2_load;
  logic accept;

  logic [WIDTH-1:0] u_q    [SHARES];
  logic [WIDTH-1:0] areg_q [NORD];
  logic [WIDTH-1:0] breg_q [NORD];
  logic [WIDTH-1:0] w_q    [NORD];

  logic [SHARES*WIDTH-1:0] c_next;

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign accept   = in_valid & rnd_valid & in_ready;

  // Stage 1: enable-gated only, so masked partials never see new randomness during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < SHARES; i++) u_q[i] <= '0;
      for (int o = 0; o < NORD; o++) begin
        areg_q[o] <= '0;
        breg_q[o] <= '0;
        w_q[o]    <= '0;
      end
    end else begin
      s1_valid <= accept | (s1_valid & ~s2_load);
      if (accept) begin
        for (int i = 0; i < SHARES; i++) begin
          u_q[i] <= a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH];
          for (int j = 0; j < SHARES; j++) begin
            if (i != j) begin
              breg_q[ord_idx(i, j)] <= b[j*WIDTH +: WIDTH] ^ r[pair_idx(i, j)*WIDTH +: WIDTH];
              areg_q[ord_idx(i, j)] <= a[i*WIDTH +: WIDTH];
              w_q[ord_idx(i, j)]    <= (~a[i*WIDTH +: WIDTH] & r[pair_idx(i, j)*WIDTH +: WIDTH])
                                       ^ p[pair_idx(i, j)*WIDTH +: WIDTH];
            end
          end
        end
      end
    end
  end

  always_comb begin
    c_next = '0;
    for (int i = 0; i < SHARES; i++) begin
      c_next[i*WIDTH +: WIDTH] = u_q[i];
      for (int j = 0; j < SHARES; j++) begin
        if (i != j) begin
          c_next[i*WIDTH +: WIDTH] = c_next[i*WIDTH +: WIDTH]
                                     ^ (areg_q[ord_idx(i, j)] & breg_q[ord_idx(i, j)])
                                     ^ w_q[ord_idx(i, j)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      out_valid <= s2_load | (out_valid & ~out_ready);
      if (s2_load) c <= c_next;
    end
  end

endmodule

// File: tb/tb_hpc3_and_pipe.sv
// tb/tb_hpc3_and_pipe.sv - randomized scoreboard bench for hpc3_and_pipe
// Reference model: recombined output must equal AND of recombined operands, in acceptance order.
module tb_hpc3_and_pipe;

  localparam int W  = 8;
  localparam int S  = 3;
  localparam int NP = S * (S - 1) / 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [S*W-1:0]  a, b, c;
  logic [NP*W-1:0] r, p;
  logic            in_valid, in_ready, rnd_valid, out_valid, out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_pop    = 0;

  logic [W-1:0]   exp_q[$];
  logic           prev_stall = 1'b0;
  logic [S*W-1:0] prev_c;

  hpc3_and_pipe #(.WIDTH(W), .SHARES(S)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .p(p), .rnd_valid(rnd_valid), .c(c), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] xor_shares(input logic [S*W-1:0] v);
    logic [W-1:0] x = '0;
    for (int i = 0; i < S; i++) x ^= v[i*W +: W];
    return x;
  endfunction

  task automatic rand_masks();
    for (int k = 0; k < NP; k++) begin
      r[k*W +: W] = W'($urandom);
      p[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic rand_operands();
    for (int i = 0; i < S; i++) begin
      a[i*W +: W] = W'($urandom);
      b[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on observed handshake, pop and compare in order on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("c_hold", c, prev_c);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_out", 1, 0);
        else begin
          check("product", xor_shares(c), exp_q.pop_front());
          n_pop++;
        end
      end
      if (in_valid && rnd_valid && in_ready) begin
        exp_q.push_back(xor_shares(a) & xor_shares(b));
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
    end
  end

  initial begin
    int k, cyc, base;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    rand_operands(); rand_masks();
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("rst_ignore_in_valid", out_valid, 0);

    // Directed product with latency check
    a = {8'h00, 8'h00, 8'h0F}; b = {8'h00, 8'h00, 8'hF3}; rand_masks();
    in_valid = 1'b1; rnd_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_edge1", out_valid, 0);
    tick();
    check("lat_edge2", out_valid, 1);
    check("direct_03", xor_shares(c), 8'h03);
    tick();

    // Masked operand, zero masks: c0 fixed by share arithmetic
    a = {8'hFF, 8'h3C, 8'h5A}; b = {8'h44, 8'h22, 8'h11}; r = '0; p = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("masked_valid", out_valid, 1);
    check("masked_c0", c[W-1:0], 8'h52);
    check("masked_xor", xor_shares(c), 8'h11);
    rand_masks();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("masked_rand_xor", xor_shares(c), 8'h11);
    tick();

    // Randomness starvation
    rand_operands(); in_valid = 1'b1; rnd_valid = 1'b0;
    repeat (5) begin
      tick();
      check("starve_no_out", out_valid, 0);
    end
    rnd_valid = 1'b1; rand_masks();
    tick();
    in_valid = 1'b0; rnd_valid = 1'b0;
    check("starve_edge1", out_valid, 0);
    tick();
    check("starve_edge2", out_valid, 1);
    tick();

    // Backpressure: 4 back-to-back transactions with consumer stalled
    base = n_pop;
    out_ready = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1;
    k = 0;
    for (cyc = 0; cyc < 30 && k < 4; cyc++) begin
      rand_operands(); rand_masks();
      out_ready = (cyc >= 6);
      @(negedge clk);
      acc = in_ready;
      if (cyc >= 2 && cyc < 6) check("bp_in_ready_low", in_ready, 0);
      tick();
      if (acc) k++;
    end
    check("bp_accepted", k, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("bp_results", n_pop - base, 4);

    // Reset mid-flight: accept at edge N, reset at edge N+1
    rand_operands(); rand_masks(); in_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_c", c, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("midrst_no_pulse", out_valid, 0);
    end

    // Random equivalence under random handshakes
    base = n_acc;
    for (cyc = 0; cyc < 60000 && (n_acc - base) < 10000; cyc++) begin
      rand_operands(); rand_masks();
      in_valid  = ($urandom_range(3) != 0);
      rnd_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    check("rand_bound", ((n_acc - base) >= 10000), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("sb_empty", exp_q.size(), 0);
    check("drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
